// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared definitions for the memory access unit. Contains the
//             RV32I load/store funct3 codes and the memory access-size codes,
//             the grant-owner enum, and small helpers for legality and
//             alignment decisions.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  // RV32I funct3 codes for loads
  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;

  // RV32I funct3 codes for stores
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  // Memory access-size codes on mem_ctrl
  localparam logic [1:0] c_ctrl_byte = 2'd0;
  localparam logic [1:0] c_ctrl_half = 2'd1;
  localparam logic [1:0] c_ctrl_word = 2'd2;

  // Owner of the memory port in the current cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } gnt_t;

  // The funct3 encodings this unit accepts for each access direction
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == c_f3_sb) || (f3 == c_f3_sh) || (f3 == c_f3_sw);
    end else begin
      ok = (f3 == c_f3_lb) || (f3 == c_f3_lh) || (f3 == c_f3_lw) ||
           (f3 == c_f3_lbu) || (f3 == c_f3_lhu);
    end
    return ok;
  endfunction

  // Access size follows funct3[1:0]; the unsigned variants share the size of
  // their signed partners. The 2'b11 pattern is never legal, so mapping it to
  // a word is harmless.
  function automatic logic [1:0] f3_size(input logic [1:0] f3_lo);
    logic [1:0] sz;
    case (f3_lo)
      2'b00:   sz = c_ctrl_byte;
      2'b01:   sz = c_ctrl_half;
      default: sz = c_ctrl_word;
    endcase
    return sz;
  endfunction

  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      c_ctrl_byte: ok = 1'b1;
      c_ctrl_half: ok = (lsb[0] == 1'b0);
      default:     ok = (lsb == 2'b00);
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Combinational load formatter. Picks the low byte/half of the
//             memory read word and sign- or zero-extends it according to the
//             load funct3; a word load passes straight through.
//  Ports    : funct3   in   3      load funct3
//             mem_data in   WIDTH  raw little-endian read data
//             data_out out  WIDTH  extended load result
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = mem_data;
    case (funct3)
      c_f3_lb:  data_out = {{(WIDTH-8){mem_data[7]}}, mem_data[7:0]};
      c_f3_lh:  data_out = {{(WIDTH-16){mem_data[15]}}, mem_data[15:0]};
      c_f3_lbu: data_out = {{(WIDTH-8){1'b0}}, mem_data[7:0]};
      c_f3_lhu: data_out = {{(WIDTH-16){1'b0}}, mem_data[15:0]};
      default:  data_out = mem_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Single-port arbiter and load/store formatter between the fetch
//             and data requesters and a unified byte-addressable memory.
//             One access is granted per cycle (data first, fetch forced after
//             STARVE_LIMIT consecutive data grants), alignment and funct3 are
//             checked, and every response is registered one cycle later.
//  Ports    : clk, rst (sync, active-low)
//             if_req/if_addr -> if_ack, if_rvalid/if_rdata/if_err
//             dm_req/dm_we/dm_addr/dm_wdata/dm_funct3
//                            -> dm_ack, dm_rvalid/dm_rdata/dm_err
//             mem_write_en/mem_addr/mem_write_data/mem_ctrl -> memory,
//             mem_data <- memory (async read)
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_ack,
  output logic                 if_rvalid,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [WORD_SIZE-1:0] dm_addr,
  input  logic [WORD_SIZE-1:0] dm_wdata,
  input  logic [2:0]           dm_funct3,
  output logic                 dm_ack,
  output logic                 dm_rvalid,
  output logic [WORD_SIZE-1:0] dm_rdata,
  output logic                 dm_err,
  output logic                 mem_write_en,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_write_data,
  output logic [1:0]           mem_ctrl,
  input  logic [WORD_SIZE-1:0] mem_data
);

  localparam int            c_cnt_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0]   r_starve_cnt;
  logic [WORD_SIZE-1:0] r_last_addr;
  logic [1:0]           r_last_ctrl;

  logic                 r_if_rvalid;
  logic [WORD_SIZE-1:0] r_if_rdata;
  logic                 r_if_err;
  logic                 r_dm_rvalid;
  logic [WORD_SIZE-1:0] r_dm_rdata;
  logic                 r_dm_err;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  gnt_t                 w_gnt;
  logic                 w_fetch_force;
  logic [1:0]           w_dm_size;
  logic                 w_dm_ok;
  logic                 w_if_ok;
  logic [WORD_SIZE-1:0] w_load_data;

  logic [WORD_SIZE-1:0] w_addr;
  logic [1:0]           w_ctrl;
  logic                 w_we;
  logic [WORD_SIZE-1:0] w_wdata;

  assign w_fetch_force = if_req && (r_starve_cnt == c_limit);
  assign w_dm_size     = f3_size(dm_funct3[1:0]);
  assign w_dm_ok       = f3_legal(dm_we, dm_funct3) &&
                         addr_aligned(w_dm_size, dm_addr[1:0]);
  assign w_if_ok       = (if_addr[1:0] == 2'b00);

  // Grant owner: data has priority unless fetch has been starved long enough.
  // Nothing is granted while reset is asserted.
  always_comb begin
    w_gnt = GNT_NONE;
    if (rst) begin
      if (dm_req && !w_fetch_force) begin
        w_gnt = GNT_DM;
      end else if (if_req) begin
        w_gnt = GNT_IF;
      end
    end
  end

  // Memory port drive; when idle the address and size hold their last values
  always_comb begin
    w_addr  = r_last_addr;
    w_ctrl  = r_last_ctrl;
    w_we    = 1'b0;
    w_wdata = '0;
    case (w_gnt)
      GNT_IF: begin
        w_addr = if_addr;
        w_ctrl = c_ctrl_word;
      end
      GNT_DM: begin
        w_addr  = dm_addr;
        w_ctrl  = w_dm_size;
        w_we    = dm_we && w_dm_ok;
        w_wdata = dm_wdata;
      end
      default: begin
        w_addr = r_last_addr;
      end
    endcase
  end

  assign if_ack         = (w_gnt == GNT_IF);
  assign dm_ack         = (w_gnt == GNT_DM);
  assign mem_write_en   = w_we;
  assign mem_addr       = rst ? w_addr  : '0;
  assign mem_ctrl       = rst ? w_ctrl  : c_ctrl_byte;
  assign mem_write_data = w_wdata;

  load_extend #(
    .WIDTH (WORD_SIZE)
  ) u_load_extend (
    .funct3   (dm_funct3),
    .mem_data (mem_data),
    .data_out (w_load_data)
  );

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
      r_last_addr  <= '0;
      r_last_ctrl  <= c_ctrl_byte;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_if_err     <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_dm_rdata   <= '0;
      r_dm_err     <= 1'b0;
    end else begin
      if ((w_gnt == GNT_IF) || !if_req) begin
        r_starve_cnt <= '0;
      end else if (w_gnt == GNT_DM) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      r_last_addr <= w_addr;
      r_last_ctrl <= w_ctrl;

      r_if_rvalid <= (w_gnt == GNT_IF);
      r_if_err    <= (w_gnt == GNT_IF) && !w_if_ok;
      r_if_rdata  <= ((w_gnt == GNT_IF) && w_if_ok) ? mem_data : '0;

      r_dm_rvalid <= (w_gnt == GNT_DM);
      r_dm_err    <= (w_gnt == GNT_DM) && !w_dm_ok;
      r_dm_rdata  <= ((w_gnt == GNT_DM) && w_dm_ok && !dm_we) ? w_load_data : '0;
    end
  end

  // A response registered just before reset asserts must not escape during
  // the reset cycle, so the registered outputs are also qualified by rst.
  assign if_rvalid = rst && r_if_rvalid;
  assign if_err    = rst && r_if_err;
  assign if_rdata  = rst ? r_if_rdata : '0;
  assign dm_rvalid = rst && r_dm_rvalid;
  assign dm_err    = rst && r_dm_err;
  assign dm_rdata  = rst ? r_dm_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit with a byte-array memory
//             and an independent reference model of grants, memory contents
//             and responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int WS = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [WS-1:0] if_addr;
  logic          if_ack, if_rvalid, if_err;
  logic [WS-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [WS-1:0] dm_addr, dm_wdata;
  logic [2:0]    dm_funct3;
  logic          dm_ack, dm_rvalid, dm_err;
  logic [WS-1:0] dm_rdata;
  logic          mem_write_en;
  logic [WS-1:0] mem_addr, mem_write_data, mem_data;
  logic [1:0]    mem_ctrl;

  always #5 clk = ~clk;

  mem_access_unit #(
    .WORD_SIZE    (WS),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_ack         (if_ack),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .if_err         (if_err),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_funct3      (dm_funct3),
    .dm_ack         (dm_ack),
    .dm_rvalid      (dm_rvalid),
    .dm_rdata       (dm_rdata),
    .dm_err         (dm_err),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_ctrl       (mem_ctrl),
    .mem_data       (mem_data)
  );

  // --------------------------------------------------------------------------
  // Memory driven by the DUT (256 bytes, address wraps)
  // --------------------------------------------------------------------------
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];
  logic       load_mem;
  logic [7:0] a0;

  assign a0       = mem_addr[7:0];
  assign mem_data = {mem[8'(a0 + 8'd3)], mem[8'(a0 + 8'd2)], mem[8'(a0 + 8'd1)], mem[a0]};

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (mem_write_en) begin
      mem[a0] <= mem_write_data[7:0];
      if (mem_ctrl != 2'd0) mem[8'(a0 + 8'd1)] <= mem_write_data[15:8];
      if (mem_ctrl == 2'd2) begin
        mem[8'(a0 + 8'd2)] <= mem_write_data[23:16];
        mem[8'(a0 + 8'd3)] <= mem_write_data[31:24];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  int            starve;
  logic          exp_if_v, exp_if_e, exp_dm_v, exp_dm_e;
  logic [WS-1:0] exp_if_d, exp_dm_d;

  logic          last_if_ack, last_dm_ack;
  logic          last_if_seen, last_dm_seen;
  logic [WS-1:0] last_if_rdata, last_dm_rdata;
  logic          last_dm_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd32(input logic [31:0] a);
    logic [31:0] v = 0;
    for (int k = 0; k < 4; k++) v = v | (32'(ref_mem[(int'(a[7:0]) + k) % 256]) << (8 * k));
    return v;
  endfunction

  function automatic bit f3_ok(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w = rd32(a);
    logic [31:0] b = w & 32'hFF;
    logic [31:0] h = w & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // One clock cycle: called at the negedge with inputs already driven.
  task automatic tick();
    bit            g_if, g_dm, ok, wr;
    int            sz;
    logic          n_if_v, n_if_e, n_dm_v, n_dm_e;
    logic [WS-1:0] n_if_d, n_dm_d;
    #1;
    if (rst) begin
      chk("if_rvalid", if_rvalid, exp_if_v);
      if (exp_if_v) begin
        chk("if_rdata", if_rdata, exp_if_d);
        chk("if_err", if_err, exp_if_e);
      end
      chk("dm_rvalid", dm_rvalid, exp_dm_v);
      if (exp_dm_v) begin
        chk("dm_rdata", dm_rdata, exp_dm_d);
        chk("dm_err", dm_err, exp_dm_e);
      end
    end else begin
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_if_rdata", if_rdata, 0);
    end
    if (if_rvalid) begin last_if_seen = 1; last_if_rdata = if_rdata; end
    if (dm_rvalid) begin last_dm_seen = 1; last_dm_rdata = dm_rdata; last_dm_err = dm_err; end

    g_dm = rst && dm_req && !(if_req && starve == SL);
    g_if = rst && if_req && !g_dm;
    sz   = acc_bytes(dm_funct3);
    ok   = f3_ok(dm_we, dm_funct3) && ((int'(dm_addr[2:0]) % sz) == 0);
    wr   = g_dm && dm_we && ok;
    chk("if_ack", if_ack, g_if);
    chk("dm_ack", dm_ack, g_dm);
    chk("mem_write_en", mem_write_en, wr);
    if (g_if) begin
      chk("if_mem_addr", mem_addr, if_addr);
      chk("if_mem_ctrl", mem_ctrl, 2);
    end
    if (g_dm) chk("dm_mem_addr", mem_addr, dm_addr);
    last_if_ack = if_ack;
    last_dm_ack = dm_ack;

    n_if_v = g_if;
    n_if_e = g_if && (if_addr[1:0] != 0);
    n_if_d = (g_if && !n_if_e) ? rd32(if_addr) : 0;
    n_dm_v = g_dm;
    n_dm_e = g_dm && !ok;
    n_dm_d = (g_dm && ok && !dm_we) ? exp_load(dm_funct3, dm_addr) : 0;

    @(posedge clk);
    if (wr) begin
      for (int k = 0; k < sz; k++)
        ref_mem[(int'(dm_addr[7:0]) + k) % 256] = 8'(dm_wdata >> (8 * k));
    end
    if (!rst || !if_req || g_if) starve = 0;
    else if (g_dm) starve++;
    exp_if_v = rst && n_if_v; exp_if_e = n_if_e; exp_if_d = n_if_d;
    exp_dm_v = rst && n_dm_v; exp_dm_e = n_dm_e; exp_dm_d = n_dm_d;
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Directed single-access vectors
  // --------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic drive_dm(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
    dm_req = 1; dm_we = we; dm_funct3 = f3; dm_addr = a; dm_wdata = wd;
  endtask

  logic [9:0] pat;

  initial begin
    vecs[0]  = '{1'b0, 3'd2, 32'h40, 32'h0,         32'h8000_00FF, 1'b0}; // LW
    vecs[1]  = '{1'b0, 3'd0, 32'h40, 32'h0,         32'hFFFF_FFFF, 1'b0}; // LB
    vecs[2]  = '{1'b0, 3'd4, 32'h40, 32'h0,         32'h0000_00FF, 1'b0}; // LBU
    vecs[3]  = '{1'b1, 3'd1, 32'h41, 32'h0000_BEEF, 32'h0,         1'b1}; // SH misaligned
    vecs[4]  = '{1'b0, 3'd2, 32'h40, 32'h0,         32'h8000_00FF, 1'b0}; // unchanged
    vecs[5]  = '{1'b1, 3'd1, 32'h42, 32'h0000_8001, 32'h0,         1'b0}; // SH
    vecs[6]  = '{1'b0, 3'd1, 32'h42, 32'h0,         32'hFFFF_8001, 1'b0}; // LH
    vecs[7]  = '{1'b0, 3'd5, 32'h42, 32'h0,         32'h0000_8001, 1'b0}; // LHU
    vecs[8]  = '{1'b0, 3'd2, 32'h40, 32'h0,         32'h8001_00FF, 1'b0}; // LW
    vecs[9]  = '{1'b1, 3'd2, 32'h80, 32'hCAFE_F00D, 32'h0,         1'b0}; // SW
    vecs[10] = '{1'b0, 3'd2, 32'h80, 32'h0,         32'hCAFE_F00D, 1'b0}; // LW
    vecs[11] = '{1'b0, 3'd3, 32'h80, 32'h0,         32'h0,         1'b1}; // funct3 011
    vecs[12] = '{1'b1, 3'd4, 32'h80, 32'h0,         32'h0,         1'b1}; // bad store f3
    vecs[13] = '{1'b0, 3'd2, 32'h82, 32'h0,         32'h0,         1'b1}; // LW misaligned
    vecs[14] = '{1'b1, 3'd0, 32'h83, 32'h1111_11AA, 32'h0,         1'b0}; // SB
    vecs[15] = '{1'b0, 3'd2, 32'h80, 32'h0,         32'hAAFE_F00D, 1'b0}; // LW
    vecs[16] = '{1'b0, 3'd0, 32'h81, 32'h0,         32'hFFFF_FFF0, 1'b0}; // LB odd
    vecs[17] = '{1'b0, 3'd1, 32'h81, 32'h0,         32'h0,         1'b1}; // LH misaligned
    vecs[18] = '{1'b0, 3'd5, 32'h80, 32'h0,         32'h0000_F00D, 1'b0}; // LHU

    rst = 0; load_mem = 1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_funct3 = 0;
    starve = 0;
    exp_if_v = 0; exp_if_e = 0; exp_if_d = 0; exp_dm_v = 0; exp_dm_e = 0; exp_dm_d = 0;
    last_if_seen = 0; last_dm_seen = 0; last_if_rdata = 0; last_dm_rdata = 0; last_dm_err = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[8'h40] = 8'hFF; ref_mem[8'h41] = 8'h00; ref_mem[8'h42] = 8'h00; ref_mem[8'h43] = 8'h80;

    @(negedge clk);
    tick();
    tick();
    load_mem = 0;
    rst = 1;
    tick();

    // Table-driven single accesses
    for (int i = 0; i < NV; i++) begin
      drive_dm(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      last_dm_seen = 0;
      tick();
      chk("vec_ack", last_dm_ack, 1);
      dm_req = 0;
      tick();
      chk("vec_rvalid", last_dm_seen, 1);
      chk("vec_rdata", last_dm_rdata, vecs[i].exp_rdata);
      chk("vec_err", last_dm_err, vecs[i].exp_err);
    end

    // Both requesters held: fetch forced after STARVE_LIMIT data grants
    if_req = 1; if_addr = 32'h40;
    drive_dm(1'b0, 3'd2, 32'h40, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      pat[i] = last_if_ack;
    end
    if_req = 0; dm_req = 0;
    tick();
    chk("starve_pattern", 32'(pat), 32'h210);

    // Back-to-back store then load of the same word
    drive_dm(1'b1, 3'd2, 32'h88, 32'h1234_5678);
    tick();
    drive_dm(1'b0, 3'd2, 32'h88, 32'h0);
    tick();
    dm_req = 0;
    tick();
    chk("b2b_load", last_dm_rdata, 32'h1234_5678);

    // Reset in the cycle after a grant suppresses the response
    drive_dm(1'b0, 3'd2, 32'h40, 32'h0);
    tick();
    drive_dm(1'b1, 3'd2, 32'h80, 32'hDEAD_BEEF);
    rst = 0;
    last_dm_seen = 0;
    tick();
    chk("rst_no_resp", last_dm_seen, 0);
    chk("rst_no_write", {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, 32'hAAFE_F00D);
    rst = 1; dm_req = 0;
    if_req = 1; if_addr = 32'h0;
    last_if_seen = 0;
    tick();
    if_req = 0;
    tick();
    chk("fetch0_seen", last_if_seen, 1);
    chk("fetch0_rdata", last_if_rdata, 32'h0);

    // Randomized traffic with requests held until acknowledged
    for (int c = 0; c < 600; c++) begin
      if (!if_req || last_if_ack) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
        if ($urandom_range(0, 3) != 0) if_addr[1:0] = 2'b00;
      end
      if (!dm_req || last_dm_ack) begin
        dm_req    = ($urandom_range(0, 3) != 0);
        dm_we     = $urandom_range(0, 1);
        dm_funct3 = $urandom_range(0, 7);
        dm_addr   = $urandom;
        dm_wdata  = $urandom;
        if ($urandom_range(0, 1) != 0) dm_addr[1:0] = 2'b00;
      end
      rst = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst = 1; if_req = 0; dm_req = 0;
    tick();
    for (int i = 0; i < 256; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
